// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcodes, issue classes and field positions
// for the instruction word, reservation-station entry and CDB word.
package tomasulo_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;

  localparam int INSTR_W   = 16;
  localparam int INS_OP_HI = 15;
  localparam int INS_OP_LO = 12;
  localparam int INS_A_HI  = 11;
  localparam int INS_A_LO  = 8;
  localparam int INS_B_HI  = 7;
  localparam int INS_B_LO  = 4;
  localparam int INS_C_HI  = 3;
  localparam int INS_C_LO  = 0;

  localparam int ENT_W     = 48;
  localparam int ENT_OP_HI = 47;
  localparam int ENT_OP_LO = 44;

  localparam int CDB_W      = 23;
  localparam int CDB_TAG_HI = 22;
  localparam int CDB_TAG_LO = 19;
  localparam int CDB_VAL_HI = 18;
  localparam int CDB_VAL_LO = 0;

  // Wide enough for a reservation station of up to 7 entries.
  localparam int CRED_W = 3;

  typedef enum logic [1:0] {CLS_ADD, CLS_MUL, CLS_BAD} op_class_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_SUB: cls = CLS_ADD;
      OP_MUL, OP_DIV: cls = CLS_MUL;
      default:        cls = CLS_BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/rs_credit.sv
// Saturating credit counter tracking free space in one reservation station.
module rs_credit
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic take,
  input  logic give,
  output logic avail,
  output logic err
);

  localparam logic [CRED_W-1:0] FULL = CRED_W'(DEPTH);

  logic [CRED_W-1:0] credit;

  // A free pulse arriving at full credit is dropped and flagged stickily.
  always_ff @(posedge clock) begin
    if (reset) begin
      credit <= FULL;
      err    <= 1'b0;
    end else if (take && !give) begin
      credit <= credit - CRED_W'(1);
    end else if (give && !take) begin
      if (credit == FULL) err <= 1'b1;
      else credit <= credit + CRED_W'(1);
    end
  end

  assign avail = (credit != '0);

endmodule

// File: rtl/issue_sequencer.sv
// Issue sequencer: pops the instruction queue into the merge pipeline, reserving
// RS credit up front, and strobes the merged entry into its RS three cycles later.
module issue_sequencer
  import tomasulo_pkg::*;
#(
  parameter int RS_ADD_DEPTH = 2,
  parameter int RS_MUL_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iq_valid,
  input  logic [INSTR_W-1:0]   iq_instr,
  output logic                 iq_pop,
  input  logic                 halt,
  output logic [INSTR_W-1:0]   merge_instr,
  output logic                 merge_ctrl,
  input  logic [ENT_W-1:0]     merge_out,
  output logic                 rs_add_we,
  output logic                 rs_mul_we,
  output logic [ENT_W-1:0]     rs_entry,
  input  logic                 rs_add_free,
  input  logic                 rs_mul_free,
  output logic                 bad_op,
  output logic                 credit_err,
  output logic                 idle,
  output logic [15:0]          issued_cnt
);

  op_class_e head_cls;
  logic      add_avail, mul_avail, add_err, mul_err;
  logic      head_ok, issue, illegal;
  logic [2:0] sh_valid;
  op_class_e sh_cls0, sh_cls1, sh_cls2;

  assign head_cls = op_class(iq_instr[INS_OP_HI:INS_OP_LO]);
  assign head_ok  = ((head_cls == CLS_ADD) && add_avail) ||
                    ((head_cls == CLS_MUL) && mul_avail);
  assign issue    = !reset && iq_valid && !halt && head_ok;
  assign illegal  = !reset && iq_valid && !halt && (head_cls == CLS_BAD);

  assign iq_pop      = issue || illegal;
  assign merge_instr = issue ? iq_instr : '0;
  assign merge_ctrl  = !reset;

  // Stage 2 lines up with mux_merge's output; reset discards anything in flight.
  assign rs_add_we  = !reset && sh_valid[2] && (sh_cls2 == CLS_ADD);
  assign rs_mul_we  = !reset && sh_valid[2] && (sh_cls2 == CLS_MUL);
  assign rs_entry   = merge_out;
  assign idle       = (sh_valid == 3'b000) && !issue;
  assign credit_err = add_err || mul_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      sh_valid   <= 3'b000;
      sh_cls0    <= CLS_ADD;
      sh_cls1    <= CLS_ADD;
      sh_cls2    <= CLS_ADD;
      bad_op     <= 1'b0;
      issued_cnt <= '0;
    end else begin
      sh_valid <= {sh_valid[1:0], issue};
      sh_cls0  <= head_cls;
      sh_cls1  <= sh_cls0;
      sh_cls2  <= sh_cls1;
      bad_op   <= illegal;
      if (issue) issued_cnt <= issued_cnt + 16'd1;
    end
  end

  rs_credit #(.DEPTH(RS_ADD_DEPTH)) u_add_credit (
    .clock (clock),
    .reset (reset),
    .take  (issue && (head_cls == CLS_ADD)),
    .give  (rs_add_free),
    .avail (add_avail),
    .err   (add_err)
  );

  rs_credit #(.DEPTH(RS_MUL_DEPTH)) u_mul_credit (
    .clock (clock),
    .reset (reset),
    .take  (issue && (head_cls == CLS_MUL)),
    .give  (rs_mul_free),
    .avail (mul_avail),
    .err   (mul_err)
  );

endmodule

// File: tb/tb_issue_sequencer.sv
// Scoreboard bench for issue_sequencer: a queue-level model predicts pops and
// RS writes; a negedge monitor matches each write strobe against the scoreboard.
module tb_issue_sequencer;

  localparam int ADD_DEPTH = 2;
  localparam int MUL_DEPTH = 2;

  typedef struct {
    int          cls;
    logic [47:0] entry;
    int          due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iq_valid = 1'b0;
  logic [15:0] iq_instr = '0;
  logic        halt = 1'b0;
  logic        rs_add_free = 1'b0;
  logic        rs_mul_free = 1'b0;
  logic        iq_pop, merge_ctrl, rs_add_we, rs_mul_we, bad_op, credit_err, idle;
  logic [15:0] merge_instr, issued_cnt;
  logic [47:0] merge_out, rs_entry;

  logic [47:0] p0 = '0, p1 = '0, p2 = '0;

  int          cyc = 0;
  int          nChecks = 0;
  int          nPass = 0;

  int          credit [2];
  bit          mErr, mBad;
  logic [15:0] mCnt;
  logic [15:0] iq [$];
  exp_t        sbq [$];
  exp_t        monE;

  bit          ePop, eIdle, eBad, eErr;
  logic [15:0] eMerge, eCnt;

  issue_sequencer #(.RS_ADD_DEPTH(ADD_DEPTH), .RS_MUL_DEPTH(MUL_DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .iq_valid    (iq_valid),
    .iq_instr    (iq_instr),
    .iq_pop      (iq_pop),
    .halt        (halt),
    .merge_instr (merge_instr),
    .merge_ctrl  (merge_ctrl),
    .merge_out   (merge_out),
    .rs_add_we   (rs_add_we),
    .rs_mul_we   (rs_mul_we),
    .rs_entry    (rs_entry),
    .rs_add_free (rs_add_free),
    .rs_mul_free (rs_mul_free),
    .bad_op      (bad_op),
    .credit_err  (credit_err),
    .idle        (idle),
    .issued_cnt  (issued_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [47:0] mergeFn(input logic [15:0] i);
    return {i, i ^ 16'hA5A5, ~i};
  endfunction

  // Stand-in for mux_merge: three registered steps advancing while mux_control is high.
  always @(posedge clock) begin
    if (merge_ctrl) begin
      p0 <= mergeFn(merge_instr);
      p1 <= p0;
      p2 <= p1;
    end
  end
  assign merge_out = p2;

  function automatic int clsOf(input logic [3:0] op);
    if (op <= 4'h1) return 0;
    if (op <= 4'h3) return 1;
    return 2;
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic modelReset();
    credit[0] = ADD_DEPTH;
    credit[1] = MUL_DEPTH;
    mErr = 1'b0;
    mBad = 1'b0;
    mCnt = '0;
    sbq.delete();
    iq.delete();
  endtask

  task automatic applyReset(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      reset = 1'b1;
      iq_valid = 1'b0;
      iq_instr = '0;
      halt = 1'b0;
      rs_add_free = 1'b0;
      rs_mul_free = 1'b0;
      modelReset();
    end
  endtask

  task automatic checkOutput();
    check("iq_pop", 48'(iq_pop), 48'(ePop));
    check("merge_instr", 48'(merge_instr), 48'(eMerge));
    check("merge_ctrl", 48'(merge_ctrl), 48'(1'b1));
    check("idle", 48'(idle), 48'(eIdle));
    check("bad_op", 48'(bad_op), 48'(eBad));
    check("issued_cnt", 48'(issued_cnt), 48'(eCnt));
    check("credit_err", 48'(credit_err), 48'(eErr));
  endtask

  task automatic applyStimulus(input bit vEn, input bit h, input bit fa, input bit fm);
    int  c, depth;
    bit  iss, ill, take, give;
    @(posedge clock);
    #1;
    reset = 1'b0;
    iq_valid = vEn && (iq.size() > 0);
    iq_instr = (iq.size() > 0) ? iq[0] : 16'($urandom);
    halt = h;
    rs_add_free = fa;
    rs_mul_free = fm;

    c   = clsOf(iq_instr[15:12]);
    iss = iq_valid && !h && (c != 2) && (credit[c > 1 ? 0 : c] > 0);
    ill = iq_valid && !h && (c == 2);
    ePop   = iss || ill;
    eMerge = iss ? iq_instr : 16'h0000;
    eIdle  = !iss && (sbq.size() == 0);
    eBad   = mBad;
    eCnt   = mCnt;
    eErr   = mErr;

    if (iss) begin
      sbq.push_back('{c, mergeFn(iq_instr), cyc + 3});
      mCnt = mCnt + 16'd1;
    end
    if (ePop) void'(iq.pop_front());
    for (int k = 0; k < 2; k++) begin
      take  = iss && (c == k);
      give  = (k == 0) ? fa : fm;
      depth = (k == 0) ? ADD_DEPTH : MUL_DEPTH;
      if (take && !give) credit[k]--;
      else if (give && !take) begin
        if (credit[k] == depth) mErr = 1'b1;
        else credit[k]++;
      end
    end
    mBad = ill;

    @(negedge clock);
    checkOutput();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, 1'b0, credit[0] < ADD_DEPTH, credit[1] < MUL_DEPTH);
  endtask

  // Monitor: every strobe must match the oldest outstanding write, on its due cycle.
  always @(negedge clock) begin
    if (reset) begin
      check("we_in_reset", 48'({rs_add_we, rs_mul_we}), 48'(2'b00));
    end else if (rs_add_we || rs_mul_we) begin
      if (sbq.size() == 0) begin
        check("unexpected_we", 48'({rs_add_we, rs_mul_we}), 48'(2'b00));
      end else begin
        monE = sbq.pop_front();
        check("we_class", 48'({rs_add_we, rs_mul_we}), (monE.cls == 0) ? 48'(2'b10) : 48'(2'b01));
        check("rs_entry", rs_entry, monE.entry);
        check("we_cycle", 48'(cyc), 48'(monE.due));
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      monE = sbq.pop_front();
      check("missing_we", 48'({rs_add_we, rs_mul_we}), (monE.cls == 0) ? 48'(2'b10) : 48'(2'b01));
    end
  end

  initial begin
    logic [3:0] op;
    modelReset();
    applyReset(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Single ADD, then return its credit.
    iq.push_back(16'h0123);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Four ADDs against two credits; one free lets the third through.
    iq.push_back(16'h0111);
    iq.push_back(16'h1222);
    iq.push_back(16'h0333);
    iq.push_back(16'h1444);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    drain(12);

    // Interleaved MUL then ADD.
    iq.push_back(16'h2456);
    iq.push_back(16'h1789);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    drain(6);

    // Illegal opcode.
    iq.push_back(16'h7abc);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Issue and free of the same class in one cycle.
    iq.push_back(16'h0aaa);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    iq.push_back(16'h1bbb);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    drain(6);

    // Halt with entries in flight.
    iq.push_back(16'h0c01);
    iq.push_back(16'h2c02);
    iq.push_back(16'h3c03);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    drain(10);

    // Randomised traffic.
    repeat (500) begin
      if (iq.size() < 6 && $urandom_range(0, 1) == 0) begin
        op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
        iq.push_back({op, 12'($urandom)});
      end
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                    (credit[0] < ADD_DEPTH) && ($urandom_range(0, 2) == 0),
                    (credit[1] < MUL_DEPTH) && ($urandom_range(0, 2) == 0));
    end

    // Free at full credit sets the sticky error.
    iq.delete();
    drain(8);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with MULs in flight discards them and restores credit.
    iq.push_back(16'h2111);
    iq.push_back(16'h3222);
    iq.push_back(16'h2333);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyReset(2);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    iq.push_back(16'h2444);
    iq.push_back(16'h3555);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check("scoreboard_empty", 48'(sbq.size()), 48'(0));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
